// File: rtl/element_loader.sv
// Element loader: buffers ten 7-bit elements, launches the search stage,
// waits for its result (or a timeout), hands it to a consumer and releases.
module element_loader #(
   parameter int TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [6:0] A0,
   output logic [6:0] A1,
   output logic [6:0] A2,
   output logic [6:0] A3,
   output logic [6:0] A4,
   output logic [6:0] A5,
   output logic [6:0] A6,
   output logic [6:0] A7,
   output logic [6:0] A8,
   output logic [6:0] A9,
   output logic       START,
   input  logic       Done1,
   input  logic [3:0] location,
   input  logic [6:0] counter1,
   output logic       ACK,
   output logic [3:0] res_loc,
   output logic [6:0] res_cycles,
   output logic       res_err,
   output logic       res_valid,
   input  logic       res_ack
);

   typedef enum logic [2:0] {LOAD, ARM, WAIT_DONE, RESULT, RELEASE} state_t;

   state_t          state, state_n;
   logic [3:0]      wr_idx;
   logic [7:0]      tmo_cnt;
   logic [9:0][6:0] elem;
   logic            ack_q;
   logic            tmo_hit;

   // Count is compared one ahead so WAIT_DONE lasts exactly TIMEOUT cycles.
   assign tmo_hit = (tmo_cnt + 8'd1) == 8'(TIMEOUT);

   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         LOAD:      if (din_valid && wr_idx == 4'd9) state_n = ARM;
         ARM:       state_n = WAIT_DONE;
         WAIT_DONE: if (Done1 || tmo_hit) state_n = RESULT;
         RESULT:    if (res_ack) state_n = RELEASE;
         RELEASE:   if (!Done1) state_n = LOAD;
         default:   state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx     <= '0;
         tmo_cnt    <= '0;
         elem       <= '0;
         res_loc    <= '0;
         res_cycles <= '0;
         res_err    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         // ACK stays up only while the search stage is still holding Done1.
         ack_q <= (state_n == RELEASE) && Done1;
         case (state)
            LOAD: if (din_valid) begin
               elem[wr_idx] <= din;
               wr_idx       <= (wr_idx == 4'd9) ? 4'd0 : wr_idx + 4'd1;
            end
            ARM: tmo_cnt <= '0;
            WAIT_DONE: begin
               if (Done1) begin
                  res_loc    <= location;
                  res_cycles <= counter1;
                  res_err    <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_hit) begin
                     res_loc    <= '0;
                     res_cycles <= '0;
                     res_err    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign din_ready = (state == LOAD);
   assign START     = (state == ARM);
   assign res_valid = (state == RESULT);
   assign ACK       = ack_q;

   assign A0 = elem[0];
   assign A1 = elem[1];
   assign A2 = elem[2];
   assign A3 = elem[3];
   assign A4 = elem[4];
   assign A5 = elem[5];
   assign A6 = elem[6];
   assign A7 = elem[7];
   assign A8 = elem[8];
   assign A9 = elem[9];

endmodule

// File: tb/tb_element_loader.sv
// Bench for element_loader: table-driven load, directed corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_element_loader;
   localparam int TMO = 8;

   typedef logic [6:0] arr_t [10];
   typedef struct {
      logic       vld;
      logic [6:0] d;
      logic       exp_rdy;
      logic       exp_start;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [6:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9;
   logic       START;
   logic       Done1 = 1'b0;
   logic [3:0] location = '0;
   logic [6:0] counter1 = '0;
   logic       ACK;
   logic [3:0] res_loc;
   logic [6:0] res_cycles;
   logic       res_err;
   logic       res_valid;
   logic       res_ack = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;
   logic [6:0] a_w [10];

   element_loader #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8), .A9(A9),
      .START(START), .Done1(Done1), .location(location), .counter1(counter1), .ACK(ACK),
      .res_loc(res_loc), .res_cycles(res_cycles), .res_err(res_err), .res_valid(res_valid),
      .res_ack(res_ack)
   );

   always #5 clk = ~clk;

   assign a_w[0] = A0; assign a_w[1] = A1; assign a_w[2] = A2; assign a_w[3] = A3;
   assign a_w[4] = A4; assign a_w[5] = A5; assign a_w[6] = A6; assign a_w[7] = A7;
   assign a_w[8] = A8; assign a_w[9] = A9;

   always @(posedge clk) if (START === 1'b1) start_cnt++;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_a(input string name, input arr_t exp);
      for (int i = 0; i < 10; i++) chk($sformatf("%s[%0d]", name, i), a_w[i], exp[i]);
   endtask

   // Streams ten elements with random idle gaps; ends in the first WAIT_DONE cycle.
   task automatic load_txn(input arr_t v, input int gap_max);
      for (int i = 0; i < 10; i++) begin
         int g = $urandom_range(gap_max, 0);
         for (int k = 0; k < g; k++) begin
            din_valid = 1'b0; din = 7'($urandom);
            chk("load_idle_ready", din_ready, 1);
            chk("load_idle_start", START, 0);
            step();
         end
         din_valid = 1'b1; din = v[i];
         chk("load_ready", din_ready, 1);
         chk("load_start", START, 0);
         step();
      end
      din_valid = 1'b0;
      chk("start_latency", START, 1);
      chk("arm_ready", din_ready, 0);
      chk_a("a_loaded", v);
      step();
   endtask

   // Search-stage model: Done1 rises in WAIT_DONE cycle d (never if d > TMO).
   // Release: Done1 is held r extra cycles after ACK is seen.
   task automatic finish_txn(input int d, input logic [3:0] loc, input logic [6:0] cnt,
                             input int hold, input int r, input arr_t exp_a);
      bit err = (d > TMO);
      int n = 0;
      int exp_n = err ? TMO : d;
      chk("start_one_cycle", START, 0);
      while (res_valid !== 1'b1 && n < 300) begin
         n++;
         if (n == d && !err) begin
            Done1 = 1'b1; location = loc; counter1 = cnt;
         end
         din_valid = 1'(($urandom));
         din = 7'($urandom);
         if (n == 1) chk("wait_ready", din_ready, 0);
         step();
      end
      din_valid = 1'b0;
      chk("wait_cycles", n, exp_n);
      location = 4'($urandom);
      counter1 = 7'($urandom);
      chk("res_loc", res_loc, err ? 0 : loc);
      chk("res_cycles", res_cycles, err ? 0 : cnt);
      chk("res_err", res_err, err);
      for (int h = 0; h < hold; h++) begin
         chk("res_valid_hold", res_valid, 1);
         chk("result_ack_low", ACK, 0);
         step();
      end
      res_ack = 1'b1;
      chk("res_valid_at_ack", res_valid, 1);
      step();
      res_ack = 1'b0;
      chk("release_res_valid", res_valid, 0);
      if (!err) begin
         for (int i = 0; i < r; i++) begin
            chk("release_ack_held", ACK, 1);
            chk("release_ready_held", din_ready, 0);
            step();
         end
      end
      Done1 = 1'b0;
      chk("release_ack", ACK, !err);
      chk("release_ready", din_ready, 0);
      step();
      chk("turnaround_ready", din_ready, 1);
      chk("load_ack", ACK, 0);
      chk("res_loc_held", res_loc, err ? 0 : loc);
      chk("res_err_held", res_err, err);
      chk_a("a_stable", exp_a);
   endtask

   initial begin
      vec_t tbl[20];
      arr_t v, z;
      int s0;

      for (int i = 0; i < 10; i++) z[i] = '0;
      @(negedge clk);
      step();
      chk("rst_ready", din_ready, 1);
      chk("rst_start", START, 0);
      chk("rst_ack", ACK, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_loc", res_loc, 0);
      chk("rst_cycles", res_cycles, 0);
      chk("rst_err", res_err, 0);
      chk_a("rst_a", z);
      reset = 1'b0;

      // Back-to-back load, Done1 five cycles after START, consumer stalls six cycles.
      for (int i = 0; i < 10; i++) v[i] = 7'((i + 1) * 10);
      s0 = start_cnt;
      load_txn(v, 0);
      finish_txn(5, 4'd7, 7'd42, 6, 1, v);
      chk("start_pulses_1", start_cnt - s0, 1);

      // Table: alternate valid/idle cycles with junk on din during idles.
      for (int i = 0; i < 10; i++) begin
         tbl[2*i] = '{1'b1, 7'((i + 1) * 10), 1'b1, 1'b0};
         if (i < 9) tbl[2*i+1] = '{1'b0, 7'h55, 1'b1, 1'b0};
      end
      tbl[19] = '{1'b1, 7'd3, 1'b0, 1'b1};
      for (int i = 0; i < 20; i++) begin
         din_valid = tbl[i].vld; din = tbl[i].d;
         chk($sformatf("tbl_ready_%0d", i), din_ready, tbl[i].exp_rdy);
         chk($sformatf("tbl_start_%0d", i), START, tbl[i].exp_start);
         step();
      end
      din_valid = 1'b0;
      chk_a("tbl_a", v);
      finish_txn(3, 4'd2, 7'd9, 0, 0, v);

      // Timeout abort, then Done1 at exactly TIMEOUT (Done1 wins).
      for (int i = 0; i < 10; i++) v[i] = 7'($urandom);
      load_txn(v, 1);
      finish_txn(TMO + 1, 4'd5, 7'd5, 2, 0, v);
      for (int i = 0; i < 10; i++) v[i] = 7'($urandom);
      load_txn(v, 0);
      finish_txn(TMO, 4'd15, 7'd127, 0, 2, v);

      // Reset after four writes, then reload 1..10.
      s0 = start_cnt;
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1; din = 7'(90 + i);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0; din_valid = 1'b0;
      chk_a("rst_mid_a", z);
      chk("rst_mid_ready", din_ready, 1);
      for (int i = 0; i < 10; i++) v[i] = 7'(i + 1);
      load_txn(v, 1);
      finish_txn(2, 4'd1, 7'd11, 1, 0, v);
      chk("start_pulses_reload", start_cnt - s0, 1);

      // Reset in WAIT_DONE with Done1 and res_ack asserted: nothing may follow.
      for (int i = 0; i < 10; i++) v[i] = 7'($urandom);
      load_txn(v, 0);
      s0 = start_cnt;
      reset = 1'b1; Done1 = 1'b1; res_ack = 1'b1; location = 4'd3; counter1 = 7'd3;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("wrst_ready", din_ready, 1);
      chk("wrst_ack", ACK, 0);
      chk("wrst_valid", res_valid, 0);
      chk("wrst_err", res_err, 0);
      chk("wrst_loc", res_loc, 0);
      chk("wrst_start", start_cnt - s0, 0);
      Done1 = 1'b0; res_ack = 1'b0;

      // Random transactions.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 10; i++) v[i] = 7'($urandom);
         s0 = start_cnt;
         load_txn(v, 2);
         finish_txn($urandom_range(TMO + 3, 1), 4'($urandom), 7'($urandom),
                    $urandom_range(3, 0), $urandom_range(2, 0), v);
         chk("rand_start_pulses", start_cnt - s0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/element_loader.md
ELEMENT_LOADER -- requirements
Module: element_loader

Interface
REQ-001 Parameter TIMEOUT, default 200, maximum cycles spent in WAIT_DONE before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 din  input  7  unsigned element value from the upstream producer.
REQ-005 din_valid  input  1  din holds a valid element this cycle.
REQ-006 din_ready  output  1  loader accepts an element this cycle.
REQ-007 A0..A9  output  7 each  buffered elements 0..9 presented to the search stage.
REQ-008 START  output  1  launch request to the search stage.
REQ-009 Done1  input  1  search stage finished; location and counter1 are valid.
REQ-010 location  input  4  index returned by the search stage.
REQ-011 counter1  input  7  cycle count returned by the search stage.
REQ-012 ACK  output  1  acknowledge to the search stage.
REQ-013 res_loc  output  4  captured location.
REQ-014 res_cycles  output  7  captured counter1.
REQ-015 res_err  output  1  result was produced by a timeout abort.
REQ-016 res_valid  output  1  result outputs are valid.
REQ-017 res_ack  input  1  consumer has taken the result.

Function
REQ-018 The FSM SHALL have exactly 5 states: LOAD, ARM, WAIT_DONE, RESULT, RELEASE.
REQ-019 LOAD: din_ready=1; on din_valid=1, din is written to slot wr_idx and wr_idx increments; the slot-9 write resets wr_idx to 0 and moves to ARM.
REQ-020 din_ready SHALL be 0 in every state except LOAD; din_valid SHALL be ignored outside LOAD.
REQ-021 A0..A9 SHALL change only on accepted LOAD writes and stay stable from ARM through RELEASE.
REQ-022 ARM: START=1 for exactly one cycle, timeout counter cleared, then WAIT_DONE.
REQ-023 WAIT_DONE: on Done1=1, capture location into res_loc and counter1 into res_cycles, set res_err=0, go to RESULT.
REQ-024 WAIT_DONE: the timeout counter (8 bit) increments each cycle Done1=0; on reaching TIMEOUT, set res_loc=0, res_cycles=0, res_err=1, go to RESULT.
REQ-025 If Done1=1 in the same cycle the count reaches TIMEOUT, Done1 SHALL win (normal capture, res_err=0).
REQ-026 RESULT: res_valid=1; the FSM holds until res_ack=1, then goes to RELEASE; res_ack outside RESULT SHALL be ignored.
REQ-027 res_loc, res_cycles and res_err SHALL hold their values until the next capture.
REQ-028 RELEASE: ACK=1 every cycle while Done1=1; on the first cycle Done1=0, ACK=0 and the FSM goes to LOAD.
REQ-029 After a timeout abort, RELEASE SHALL last exactly one cycle when Done1=0.
REQ-030 START, ACK, din_ready and res_valid SHALL be registered outputs decoded from the state register, with no combinational path from any input.
REQ-031 Latency: the 10th accepted write at edge N gives START=1 during cycle N+1.
REQ-032 Minimum turnaround: res_ack to din_ready=1 is 2 cycles when Done1 falls 1 cycle after ACK.

Reset
REQ-033 Reset SHALL force state=LOAD, wr_idx=0, timeout counter=0.
REQ-034 Reset SHALL force A0..A9=0, res_loc=0, res_cycles=0, res_err=0.
REQ-035 After reset, START=0, ACK=0 and res_valid=0, and din_ready=1 from the first cycle after reset.
REQ-036 Reset asserted in any state, including mid-load or in WAIT_DONE, SHALL abandon the operation with no START or ACK emitted in that cycle or later.

Verification
REQ-037 Load 10,20,...,100 with din_valid held high -> A0=10..A9=100, START one cycle exactly 1 cycle after the 10th write.
REQ-038 Same load with din_valid low on alternate cycles -> identical A0..A9, din_ready high throughout LOAD.
REQ-039 Search model returns Done1 5 cycles after START with location=7, counter1=42 -> res_loc=7, res_cycles=42, res_err=0, res_valid=1.
REQ-040 Hold res_ack low 6 cycles, then pulse it -> res_valid stays high 6 cycles, ACK asserts next cycle, Done1 falls, din_ready=1.
REQ-041 TIMEOUT=8 with Done1 never asserted -> res_err=1, res_loc=0, res_cycles=0 after 8 WAIT_DONE cycles; after res_ack, RELEASE lasts 1 cycle.
REQ-042 Reset after 4 of 10 writes, then 10 new writes 1..10 -> A0..A9=1..10 and exactly one START pulse.
